// File: rtl/sw_disp_scan.sv
// sw_disp_scan: multiplexed 4-digit common-anode 7-segment driver
// for mm.ss stopwatch digits, with frame snapshot and dead time.
module sw_disp_scan #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEAD     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       blank,
  input  logic [3:0] min_high,
  input  logic [3:0] min_low,
  input  logic [3:0] sec_high,
  input  logic [3:0] sec_low,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned CW =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEAD_C  = CW'(DEAD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;
  logic          first_q, first_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          wrap;
  logic          off;
  logic [3:0]    digit;

  // gfedcba, active-low; non-BCD codes show a dash
  function automatic logic [6:0] enc(input logic [3:0] v);
    case (v)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0010000;
      default: enc = 7'b0111111;
    endcase
  endfunction

  // State register: slot counter, digit index, snapshot, outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      first_q <= 1'b1;
      an_q    <= 4'hF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      first_q <= first_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  // Next state: slot timing and once-per-frame digit snapshot
  always_comb begin
    wrap    = (cnt_q == CNT_MAX);
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    idx_d   = wrap ? idx_q + 2'd1 : idx_q;
    first_d = 1'b0;
    snap_d  = snap_q;
    if (first_q || (wrap && idx_q == 2'd3))
      snap_d = {min_high, min_low, sec_high, sec_low};
  end

  // Output function on pre-edge state, registered next edge
  always_comb begin
    digit = snap_q[3:0];
    an_d  = 4'b1110;
    unique case (1'b1)
      idx_q == 2'd0: begin
        digit = snap_q[3:0];
        an_d  = 4'b1110;
      end
      idx_q == 2'd1: begin
        digit = snap_q[7:4];
        an_d  = 4'b1101;
      end
      idx_q == 2'd2: begin
        digit = snap_q[11:8];
        an_d  = 4'b1011;
      end
      idx_q == 2'd3: begin
        digit = snap_q[15:12];
        an_d  = 4'b0111;
      end
    endcase
    off = blank || (cnt_q < DEAD_C) ||
          (idx_q == 2'd3 && snap_q[15:12] == 4'd0);
    seg_d = enc(digit);
    dp_d  = !(idx_q == 2'd2);
    if (off) begin
      an_d  = 4'hF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: doc/sw_disp_scan.md
# sw_disp_scan

Time-multiplexed 4-digit seven-segment driver that consumes the stopwatch BCD digits (minutes high/low, seconds high/low) and scans them onto a common-anode display. It sits after the seconds/minutes counters on the fast system clock. It snapshots all four digits once per frame to prevent tearing, inserts dead time between digits against ghosting, and applies leading-zero blanking and a minutes/seconds separator dot.

## Interface
- SCAN_DIV, 50000: clock cycles per digit slot; legal range is DEAD+2 or more.
- DEAD, 16: cycles at the start of each slot with all anodes off; minimum 1.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- blank  in  1  synchronous; 1 forces the display dark while the counters keep running.
- min_high, min_low, sec_high, sec_low  in  4 each  BCD digits from the counters; may change at any time.
- an  out  4  digit enables, active-low: an[0]=sec_low, an[1]=sec_high, an[2]=min_low, an[3]=min_high.
- seg  out  7  segments, active-low, ordered gfedcba (seg[0]=a).
- dp  out  1  decimal point, active-low.

## Operation
- Slot counter cnt runs 0..SCAN_DIV-1 and wraps to 0. On wrap, digit index idx (2 bits) increments mod 4.
- Snapshot register holds the four digits and loads all of them in one cycle:
  - on the first clock edge after reset deasserts;
  - on every edge where idx==3 and cnt==SCAN_DIV-1 (frame boundary).
  - Between loads, changes on the digit inputs are invisible.
- Output function f(idx, cnt, snapshot, blank), registered into an/seg/dp:
  - Display off (an=1111, seg=1111111, dp=1) if blank==1, or cnt<DEAD, or (idx==3 and snapshot min_high==0).
  - Otherwise an = ~(1<<idx) and seg = encode(snapshot digit[idx]).
  - dp=0 only when idx==2 and the display is not off. This is the mm.ss separator.
- Encoding (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 shows a dash, 0111111.
- Only min_high is leading-zero blanked. sec_high values 6..9 display normally; no range check beyond BCD.
- Reset (async, any time): an=1111, seg=1111111, dp=1, cnt=0, idx=0, snapshot=0, first-load flag set. Reset mid-slot discards the slot with no partial frame.

## Timing
- All outputs are registered with one-cycle latency. The output after edge k reflects f evaluated on state before edge k.
- After reset release, edges 1..DEAD give the display off. Edge DEAD+1 gives an=1110 showing the snapshot loaded at edge 1.
- Each digit is lit for SCAN_DIV-DEAD edges, then dark for DEAD edges. Frame period is 4*SCAN_DIV cycles.
- blank asserted before edge k turns the display off after edge k. On release, the display resumes at the current slot position with no counter reset.
- A digit input change made at or before the loading edge appears from the next lit slot of the new frame. A change made later waits one full frame.
- Snapshot load and output evaluation on the same edge: output uses the old snapshot, since its value is pre-edge state.

## Test plan
- SCAN_DIV=8, DEAD=2, digits 1,2,3,4 (mh,ml,sh,sl), reset released:
  - edges 1–2 give an=1111;
  - edges 3–8 give an=1110, seg=0011001;
  - edges 11–16 give an=1101, seg=0110000;
  - edges 19–24 give an=1011, seg=0100100, dp=0;
  - edges 27–32 give an=0111, seg=1111001.
- min_high=0, other digits 5,9,7: slot 3 stays an=1111, seg=1111111 for the whole slot. Slots 0–2 show 7, 9, 5.
- Inputs change from 0,0,0,0 to 1,2,3,4 mid-frame (during idx==1): the current frame still shows 0s (min_high blanked). The next frame shows 1,2,3,4.
- sec_low=4'hC: slot 0 shows seg=0111111.
- blank pulsed high for 3 cycles during a lit slot: an=1111 exactly 3 edges later-shifted by one cycle. Slot boundaries are unchanged afterwards.
- reset asserted mid-slot while idx==2: an/seg/dp go to 1111/1111111/1 immediately, without waiting for a clock edge. After release, the scan restarts at idx=0 with the DEAD gap.
